// File: rtl/mem_rmw_ctrl.sv
// Data-memory store controller: full-word stores go straight through, half/byte
// stores become a two-cycle read-modify-write of the containing word.
module mem_rmw_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      addr_in,
   input  logic [31:0]      wdata_in,
   input  logic             mem_write_in,
   input  logic [1:0]       size_in,
   input  logic [31:0]      ram_rdata_in,
   output logic [31:0]      ram_addr_out,
   output logic [31:0]      ram_wdata_out,
   output logic             ram_we_out,
   output logic             stall_out,
   output logic             align_err_out,
   output logic [CNT_W-1:0] rmw_cnt_out
);

   typedef enum logic {IDLE, WRITE} state_t;

   state_t      state;
   logic [31:0] addr_q, old_q;
   logic [15:0] wdata_q;
   logic [1:0]  size_q;

   logic        word_ok, sub_ok, bad;
   logic [3:0]  be;
   logic [31:0] wrep, merged;

   always_comb begin
      word_ok = mem_write_in && (size_in == 2'b00) && (addr_in[1:0] == 2'b00);
      sub_ok  = mem_write_in && (((size_in == 2'b01) && !addr_in[0]) || (size_in == 2'b10));
      bad     = mem_write_in && !word_ok && !sub_ok;
   end

   // Replicate the store data across the word, then pick lanes with a byte mask.
   always_comb begin
      be = 4'b0000;
      case (size_q)
         2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
         2'b10:   be = 4'b0001 << addr_q[1:0];
         default: be = 4'b0000;
      endcase
      wrep = (size_q == 2'b01) ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
   end

   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign merged[8*i +: 8] = be[i] ? wrep[8*i +: 8] : old_q[8*i +: 8];
   end

   // Strobes are forced low during reset so an aborted WRITE never reaches the RAM.
   always_comb begin
      ram_addr_out  = (state == WRITE) ? addr_q : addr_in;
      ram_wdata_out = (state == WRITE) ? merged : wdata_in;
      ram_we_out    = 1'b0;
      stall_out     = 1'b0;
      align_err_out = 1'b0;
      if (!rst) begin
         if (state == WRITE) begin
            ram_we_out = 1'b1;
         end else begin
            ram_we_out    = word_ok;
            stall_out     = sub_ok;
            align_err_out = bad;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         size_q      <= '0;
         old_q       <= '0;
         rmw_cnt_out <= '0;
      end else begin
         case (state)
            IDLE: if (sub_ok) begin
               addr_q  <= addr_in;
               wdata_q <= wdata_in[15:0];
               size_q  <= size_in;
               old_q   <= ram_rdata_in;
               state   <= WRITE;
            end
            WRITE: begin
               state <= IDLE;
               if (rmw_cnt_out != {CNT_W{1'b1}})
                  rmw_cnt_out <= rmw_cnt_out + CNT_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Bench for mem_rmw_ctrl: small word RAM model, reference memory, and a queue of
// expected RAM writes checked whenever the DUT strobes ram_we_out.
module tb_mem_rmw_ctrl;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [31:0]      addr_in = '0, wdata_in = '0;
   logic             mem_write_in = 1'b0;
   logic [1:0]       size_in = 2'b00;
   logic [31:0]      ram_rdata_in, ram_addr_out, ram_wdata_out;
   logic             ram_we_out, stall_out, align_err_out;
   logic [CNT_W-1:0] rmw_cnt_out;

   mem_rmw_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .addr_in(addr_in), .wdata_in(wdata_in),
      .mem_write_in(mem_write_in), .size_in(size_in), .ram_rdata_in(ram_rdata_in),
      .ram_addr_out(ram_addr_out), .ram_wdata_out(ram_wdata_out), .ram_we_out(ram_we_out),
      .stall_out(stall_out), .align_err_out(align_err_out), .rmw_cnt_out(rmw_cnt_out)
   );

   always #5 clk = ~clk;

   // 16-word data RAM with combinational read
   logic [31:0] mem [16];
   assign ram_rdata_in = mem[ram_addr_out[5:2]];
   always @(posedge clk) if (ram_we_out) mem[ram_addr_out[5:2]] <= ram_wdata_out;

   logic [31:0] refm [16];
   logic [63:0] sb_q [$];
   int          n_chk = 0, n_fail = 0;
   int          exp_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ram_we_out === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_we", {ram_addr_out[31:2], 2'b00}, 32'hFFFF_FFFF);
         end else begin
            logic [63:0] e;
            e = sb_q.pop_front();
            chk("we_addr", {ram_addr_out[31:2], 2'b00}, e[63:32]);
            chk("we_data", ram_wdata_out, e[31:0]);
         end
      end
   end

   // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 with the DUT in IDLE.
   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      logic        is_word, is_sub;
      logic [31:0] w;
      is_word = (sz == 2'b00) && (a[1:0] == 2'b00);
      is_sub  = ((sz == 2'b01) && !a[0]) || (sz == 2'b10);
      addr_in = a; wdata_in = d; size_in = sz; mem_write_in = 1'b1;
      w = refm[a[5:2]];
      if (is_word) w = d;
      else if (sz == 2'b01) begin
         if (a[1]) w[31:16] = d[15:0];
         else      w[15:0]  = d[15:0];
      end else if (sz == 2'b10) w[a[1:0]*8 +: 8] = d[7:0];
      if (is_word || is_sub) begin
         sb_q.push_back({a[31:2], 2'b00, w});
         refm[a[5:2]] = w;
      end
      @(negedge clk);
      chk("idle_addr", ram_addr_out, a);
      chk("idle_we",   {31'b0, ram_we_out},    {31'b0, is_word});
      chk("idle_stall",{31'b0, stall_out},     {31'b0, is_sub});
      chk("idle_err",  {31'b0, align_err_out}, {31'b0, !(is_word || is_sub)});
      @(posedge clk); #1;
      if (is_sub) begin
         addr_in = 32'h0000_0030; wdata_in = 32'h5A5A_5A5A;  // ignored while in WRITE
         @(negedge clk);
         chk("wr_we",    {31'b0, ram_we_out}, 32'd1);
         chk("wr_stall", {31'b0, stall_out},  32'd0);
         chk("wr_addr",  ram_addr_out, a);
         @(posedge clk); #1;
         if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
         chk("cnt", {{(32-CNT_W){1'b0}}, rmw_cnt_out}, exp_cnt);
      end
   endtask

   task automatic idle_cycle();
      mem_write_in = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      addr_in = 32'h40;
      #1;
      chk("rst_we",    {31'b0, ram_we_out},    32'd0);
      chk("rst_stall", {31'b0, stall_out},     32'd0);
      chk("rst_err",   {31'b0, align_err_out}, 32'd0);
      chk("rst_cnt",   {{(32-CNT_W){1'b0}}, rmw_cnt_out}, 32'd0);
      chk("rst_addr",  ram_addr_out, 32'h40);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 16; i++) do_store(i * 4, 32'h1000_0000 + i * 32'h0101, 2'b00);
      do_store(32'h8, 32'hDEAD_BEEF, 2'b00);
      do_store(32'h4, 32'h1122_3344, 2'b00);
      do_store(32'h6, 32'h0000_ABCD, 2'b01);
      idle_cycle();
      chk("w1_merge", mem[1], 32'hABCD_3344);
      chk("w2_word",  mem[2], 32'hDEAD_BEEF);
      do_store(32'h0, 32'hAABB_CCDD, 2'b00);
      do_store(32'h1, 32'h0000_0055, 2'b10);
      do_store(32'h3, 32'h0000_0066, 2'b10);
      idle_cycle();
      chk("w0_b2b", mem[0], 32'h66BB_55DD);

      do_store(32'h5, 32'h0000_1234, 2'b01);
      do_store(32'h2, 32'h1234_5678, 2'b00);
      do_store(32'hC, 32'h1234_5678, 2'b11);
      idle_cycle();
      chk("w1_noerr", mem[1], 32'hABCD_3344);

      addr_in = 32'h4;
      #1;
      chk("load_addr",  ram_addr_out, 32'h4);
      chk("load_rdata", ram_rdata_in, refm[1]);
      chk("load_we",    {31'b0, ram_we_out}, 32'd0);

      for (int k = 0; k < 60; k++) begin
         a  = $urandom_range(0, 63);
         sz = 2'($urandom_range(0, 3));
         if (sz == 2'b00 && $urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         do_store(a, $urandom, sz);
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end
      idle_cycle();

      // Abort a byte RMW by asserting reset in its WRITE cycle
      addr_in = 32'h0; wdata_in = 32'hEE; size_in = 2'b10; mem_write_in = 1'b1;
      @(negedge clk);
      chk("abort_stall", {31'b0, stall_out}, 32'd1);
      @(posedge clk); #2;
      addr_in = 32'h10; mem_write_in = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("abort_we",    {31'b0, ram_we_out}, 32'd0);
      chk("abort_stall2",{31'b0, stall_out},  32'd0);
      chk("abort_cnt",   {{(32-CNT_W){1'b0}}, rmw_cnt_out}, 32'd0);
      chk("abort_idle",  ram_addr_out, 32'h10);
      exp_cnt = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      do_store(32'h10, 32'hCAFE_F00D, 2'b00);
      do_store(32'h12, 32'h0000_7777, 2'b01);
      idle_cycle();

      for (int i = 0; i < 16; i++) chk($sformatf("mem%0d", i), mem[i], refm[i]);
      chk("sb_empty", sb_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
